// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the 64-bit ALU: decodes RV64I OP/OP-IMM
// into ALU op code and operands, with a 2-entry skid buffer so in_ready is
// a registered signal.
module alu_issue_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [5:0] SH_ZERO    = 6'b000000;
    localparam logic [5:0] SH_ALT     = 6'b010000;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t dec_c;

    logic accept_c;
    logic handoff_c;

    assign accept_c  = in_valid && in_ready;
    assign handoff_c = out_valid && out_ready;

    assign alu_op  = main_q.op;
    assign alu_a   = main_q.a;
    assign alu_b   = main_q.b;
    assign rd      = main_q.rd;
    assign illegal = main_q.ill;

    // Instruction decode; illegal encodings leave op/a/b at zero.
    always_comb begin
        logic [6:0]      opc;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [5:0]      sh_hi;
        logic [3:0]      op;
        logic            ok;
        logic [XLEN-1:0] b_val;

        opc   = instr[6:0];
        f3    = instr[14:12];
        f7    = instr[31:25];
        sh_hi = instr[31:26];
        op    = OP_ADD;
        ok    = 1'b0;
        b_val = '0;

        if (opc == OPC_OP) begin
            b_val = rs2_val;
            case (f3)
                3'b000: begin
                    ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    op = (f7 == F7_ALT) ? OP_SUB : OP_ADD;
                end
                3'b001:  begin ok = (f7 == F7_ZERO); op = OP_SLL;  end
                3'b010:  begin ok = (f7 == F7_ZERO); op = OP_SLT;  end
                3'b011:  begin ok = (f7 == F7_ZERO); op = OP_SLTU; end
                3'b100:  begin ok = (f7 == F7_ZERO); op = OP_XOR;  end
                3'b101: begin
                    ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    op = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
                end
                3'b110:  begin ok = (f7 == F7_ZERO); op = OP_OR;   end
                default: begin ok = (f7 == F7_ZERO); op = OP_AND;  end
            endcase
        end else if (opc == OPC_OP_IMM) begin
            b_val = XLEN'($signed(instr[31:20]));
            case (f3)
                3'b000:  begin ok = 1'b1; op = OP_ADD;  end
                3'b001: begin
                    ok    = (sh_hi == SH_ZERO);
                    op    = OP_SLL;
                    b_val = XLEN'(instr[25:20]);
                end
                3'b010:  begin ok = 1'b1; op = OP_SLT;  end
                3'b011:  begin ok = 1'b1; op = OP_SLTU; end
                3'b100:  begin ok = 1'b1; op = OP_XOR;  end
                3'b101: begin
                    ok    = (sh_hi == SH_ZERO) || (sh_hi == SH_ALT);
                    op    = (sh_hi == SH_ALT) ? OP_SRA : OP_SRL;
                    b_val = XLEN'(instr[25:20]);
                end
                3'b110:  begin ok = 1'b1; op = OP_OR;   end
                default: begin ok = 1'b1; op = OP_AND;  end
            endcase
        end

        dec_c.rd  = instr[11:7];
        dec_c.ill = !ok;
        dec_c.op  = ok ? op : OP_ADD;
        dec_c.a   = ok ? rs1_val : '0;
        dec_c.b   = ok ? b_val : '0;
    end

    // Occupancy FSM: main register feeds the ALU, skid holds the overflow entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept_c) begin
                        main_q    <= dec_c;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && handoff_c) begin
                        main_q <= dec_c;
                    end else if (accept_c) begin
                        skid_q   <= dec_c;
                        in_ready <= 1'b0;
                        state    <= ST_TWO;
                    end else if (handoff_c) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (handoff_c) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Handoff counters; a handoff in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt   <= '0;
            illegal_cnt <= '0;
        end else if (handoff_c) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (main_q.ill) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage directly upstream of the 64-bit ALU wrapper.
- Accepts RV64I OP / OP-IMM instructions with register-file read values, decodes them into the ALU's 4-bit op code and a/b operands, and presents them through a registered valid/ready interface.
- Holds a 2-entry skid buffer so in_ready is a registered signal and no transaction is lost under backpressure.

Parameters:
- XLEN, 64, operand/result width (ALU is 64-bit; other values unsupported).
- CNT_W, 32, width of issue and illegal counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous: discard all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept (registered, = skid entry empty)
- instr  in  32  RV instruction word
- rs1_val  in  XLEN  rs1 register value
- rs2_val  in  XLEN  rs2 register value
- out_valid  out  1  alu_* fields valid
- out_ready  in  1  ALU side consumes
- alu_op  out  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SRL,6 SLL,7 SRA,8 SLT,9 SLTU
- alu_a  out  XLEN  operand a
- alu_b  out  XLEN  operand b (shift amount in b[5:0] for shifts)
- rd  out  5  destination register
- illegal  out  1  entry failed decode
- issue_cnt  out  CNT_W  entries handed off (out_valid&&out_ready)
- illegal_cnt  out  CNT_W  illegal entries handed off

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low; ports are clk and rst_n.
- Reset (rst_n=0, immediate): out_valid=0, skid empty, in_ready=1, alu_op=0, alu_a=0, alu_b=0, rd=0, illegal=0, both counters 0.
- Accept when in_valid&&in_ready. Handoff when out_valid&&out_ready.
- Decode, registered on accept. opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]; imm = sign-extend instr[31:20] to XLEN.
- OP (0110011), a=rs1_val, b=rs2_val:
  - f3 000: ADD if f7=0000000, SUB if f7=0100000.
  - f3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; each requires f7=0000000.
  - f3 101: SRL if f7=0000000, SRA if f7=0100000.
  - Any other f7: illegal.
- OP-IMM (0010011), a=rs1_val, b=imm:
  - f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - f3 001 SLL: requires instr[31:26]=000000.
  - f3 101: SRL if instr[31:26]=000000, SRA if 010000.
  - Shifts: b = zero-extended instr[25:20].
- Any other opcode or illegal encoding: illegal=1, alu_op=0, a=b=0, rd still passed (instr[11:7]).
- FSM on occupancy:
  - EMPTY: accept -> ONE (out_valid=1 next cycle; latency 1).
  - ONE: accept & handoff -> ONE (main reg reloads); accept & no handoff -> TWO (new entry into skid); handoff only -> EMPTY.
  - TWO: in_ready=0; handoff -> ONE with skid moved to main reg next cycle, order preserved.
- in_ready = skid empty (registered; never combinationally dependent on out_ready).
- Output fields are stable while out_valid=1 and out_ready=0.
- flush: next state EMPTY and in_ready=1 regardless of in_valid/out_ready. A same-cycle accept is dropped. A same-cycle handoff still counts (counters increment).
- Counters: issue_cnt +1 per handoff; illegal_cnt +1 per handoff with illegal=1. Both wrap modulo 2^CNT_W without saturation.
- rst_n asserted mid-transfer: buffered entries lost, no partial outputs.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=10, rs2=20, out_ready=1 -> next cycle out_valid=1, alu_op=0, a=10, b=20, rd=3, issue_cnt=1 after handoff.
- sub (0x402081B3), rs1=10, rs2=20 -> alu_op=1. addi x1,x0,-1 (0xFFF00093) -> alu_op=0, b=0xFFFFFFFFFFFFFFFF.
- srai x5,x1,4 (0x4040D293), rs1=0x8000000000000000 -> alu_op=7, b=4, rd=5.
- Backpressure:
  - out_ready=0, offer 3 instrs A,B,C -> A,B accepted, in_ready=0 from cycle after B, C held.
  - out_ready=1 -> A then B handed off in order, then C accepted.
- ecall (0x00000073) and add with f7=0000001 -> illegal=1, alu_op=0, illegal_cnt=2 after both handoffs.
- Flush: buffer in TWO, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged; async rst_n mid-TWO -> all outputs at reset values immediately.
